// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase sequencer with pedestrian WALK insertion.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | parked after reset/restart, leaves to G1 next clock
// G1     | road 1 green, road 2 red
// Y1     | road 1 yellow, road 2 red
// AR_A   | all red after road 1, may branch to WALK
// G2     | road 2 green, road 1 red
// Y2     | road 2 yellow, road 1 red
// AR_B   | all red after road 2, may branch to WALK
// WALK   | all red, walk lamps lit, then return phase
module traffic_phase_scheduler #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             hold_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] grn_len_i,
    input  logic [CNT_W-1:0] yel_len_i,
    input  logic [CNT_W-1:0] red_len_i,
    input  logic [CNT_W-1:0] walk_len_i,
    input  logic [1:0]       ped_req_i,
    output logic [2:0]       light1_o,
    output logic [2:0]       light2_o,
    output logic [1:0]       walk_o,
    output logic [1:0]       ped_pend_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [2:0]       phase_o,
    output logic             phase_done_o
);

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_G1   = 3'd1,
        P_Y1   = 3'd2,
        P_AR_A = 3'd3,
        P_G2   = 3'd4,
        P_Y2   = 3'd5,
        P_AR_B = 3'd6,
        P_WALK = 3'd7
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    phase_e           phase_q, phase_d;
    phase_e           ret_q, ret_d;
    phase_e           nxt_phase;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       walk_q, walk_d;
    logic [1:0]       pend_q, pend_d;
    logic             done_q, done_d;
    logic [1:0]       req_all;

    // Length of a phase as loaded on entry; zero is stretched to one tick.
    function automatic logic [CNT_W-1:0] phase_len(
        input phase_e           p,
        input logic [CNT_W-1:0] grn,
        input logic [CNT_W-1:0] yel,
        input logic [CNT_W-1:0] red,
        input logic [CNT_W-1:0] wlk
    );
        logic [CNT_W-1:0] len;
        case (p)
            P_G1, P_G2:     len = grn;
            P_Y1, P_Y2:     len = yel;
            P_AR_A, P_AR_B: len = red;
            P_WALK:         len = wlk;
            default:        len = '0;
        endcase
        if (len == '0) begin
            len = CNT_W'(1);
        end
        return len;
    endfunction

    assign req_all = pend_q | ped_req_i;

    // State register: phase, counter, walk lamps, pending requests, return phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= P_IDLE;
            ret_q   <= P_G1;
            cnt_q   <= '0;
            walk_q  <= '0;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            walk_q  <= walk_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: restart beats hold, hold beats tick; requests always latch.
    always_comb begin
        phase_d   = phase_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        walk_d    = walk_q;
        pend_d    = req_all;
        done_d    = 1'b0;
        nxt_phase = phase_q;

        if (restart_i) begin
            phase_d = P_IDLE;
            ret_d   = P_G1;
            cnt_d   = '0;
            walk_d  = '0;
        end else if (!hold_i) begin
            if (phase_q == P_IDLE) begin
                phase_d = P_G1;
                cnt_d   = phase_len(P_G1, grn_len_i, yel_len_i, red_len_i, walk_len_i);
            end else if (tick_i) begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_d = 1'b1;
                    case (phase_q)
                        P_G1:   nxt_phase = P_Y1;
                        P_Y1:   nxt_phase = P_AR_A;
                        P_G2:   nxt_phase = P_Y2;
                        P_Y2:   nxt_phase = P_AR_B;
                        P_AR_A: begin
                            if (req_all != 2'b00) begin
                                nxt_phase = P_WALK;
                                ret_d     = P_G2;
                            end else begin
                                nxt_phase = P_G2;
                            end
                        end
                        P_AR_B: begin
                            if (req_all != 2'b00) begin
                                nxt_phase = P_WALK;
                                ret_d     = P_G1;
                            end else begin
                                nxt_phase = P_G1;
                            end
                        end
                        P_WALK:  nxt_phase = ret_q;
                        default: nxt_phase = P_IDLE;
                    endcase
                    // Serving a crossing consumes its pending bit; WALK exit darkens the lamps.
                    if (nxt_phase == P_WALK) begin
                        walk_d = req_all;
                        pend_d = '0;
                    end else if (phase_q == P_WALK) begin
                        walk_d = '0;
                    end
                    phase_d = nxt_phase;
                    cnt_d   = phase_len(nxt_phase, grn_len_i, yel_len_i, red_len_i, walk_len_i);
                end
            end
        end
    end

    // Output decode: lamps follow the current phase, everything else is registered.
    always_comb begin
        light1_o = LAMP_RED;
        light2_o = LAMP_RED;
        case (phase_q)
            P_G1:    light1_o = LAMP_GRN;
            P_Y1:    light1_o = LAMP_YEL;
            P_G2:    light2_o = LAMP_GRN;
            P_Y2:    light2_o = LAMP_YEL;
            default: begin
                light1_o = LAMP_RED;
                light2_o = LAMP_RED;
            end
        endcase
        walk_o       = walk_q;
        ped_pend_o   = pend_q;
        cnt_o        = cnt_q;
        phase_o      = phase_q;
        phase_done_o = done_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic
// against a phase-table reference model.
module tb_traffic_phase_scheduler;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       hold;
    logic       restart;
    logic [3:0] grn, yel, red, wlk;
    logic [1:0] req;
    logic [2:0] light1, light2;
    logic [1:0] walk, pend;
    logic [3:0] cnt;
    logic [2:0] phase;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int         m_phase, m_left, m_ret;
    logic [1:0] m_walk, m_pend;
    bit         m_done;

    int         succ   [0:7] = '{0, 2, 3, 4, 5, 6, 1, 0};
    logic [2:0] lamp1  [0:7] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] lamp2  [0:7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    int         exp_ph [0:9] = '{1, 1, 2, 3, 4, 4, 4, 5, 6, 1};
    int         exp_ct [0:9] = '{2, 1, 1, 1, 3, 2, 1, 1, 1, 3};

    traffic_phase_scheduler #(.CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_i       (tick),
        .hold_i       (hold),
        .restart_i    (restart),
        .grn_len_i    (grn),
        .yel_len_i    (yel),
        .red_len_i    (red),
        .walk_len_i   (wlk),
        .ped_req_i    (req),
        .light1_o     (light1),
        .light2_o     (light2),
        .walk_o       (walk),
        .ped_pend_o   (pend),
        .cnt_o        (cnt),
        .phase_o      (phase),
        .phase_done_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mlen(input int p);
        int v;
        case (p)
            1, 4:    v = int'(grn);
            2, 5:    v = int'(yel);
            3, 6:    v = int'(red);
            default: v = int'(wlk);
        endcase
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_ret   = 1;
        m_walk  = 2'b00;
        m_pend  = 2'b00;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input bit tk, input bit hd, input bit rs, input logic [1:0] rq);
        logic [1:0] any;
        any    = m_pend | rq;
        m_done = 1'b0;
        m_pend = any;
        if (rs) begin
            m_phase = 0;
            m_left  = 0;
            m_walk  = 2'b00;
            m_ret   = 1;
        end else if (hd) begin
            // frozen
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_left  = mlen(1);
        end else if (tk && m_left > 1) begin
            m_left = m_left - 1;
        end else if (tk) begin
            m_done = 1'b1;
            if ((m_phase == 3 || m_phase == 6) && any != 2'b00) begin
                m_ret   = (m_phase == 3) ? 4 : 1;
                m_walk  = any;
                m_pend  = 2'b00;
                m_phase = 7;
            end else if (m_phase == 7) begin
                m_walk  = 2'b00;
                m_phase = m_ret;
            end else begin
                m_phase = succ[m_phase];
            end
            m_left = mlen(m_phase);
        end
    endtask

    task automatic compare_all();
        chk("phase",  int'(phase),  m_phase);
        chk("cnt",    int'(cnt),    m_left);
        chk("walk",   int'(walk),   int'(m_walk));
        chk("pend",   int'(pend),   int'(m_pend));
        chk("done",   int'(done),   int'(m_done));
        chk("light1", int'(light1), int'(lamp1[m_phase]));
        chk("light2", int'(light2), int'(lamp2[m_phase]));
    endtask

    // Called at a falling edge: apply inputs, clock once, check at the next falling edge.
    task automatic drive_cycle(input bit tk, input bit hd, input bit rs, input logic [1:0] rq);
        tick    = tk;
        hold    = hd;
        restart = rs;
        req     = rq;
        @(posedge clk);
        model_step(tk, hd, rs, rq);
        @(negedge clk);
        compare_all();
        tick    = 1'b0;
        restart = 1'b0;
        req     = 2'b00;
    endtask

    task automatic do_tick(input logic [1:0] rq);
        drive_cycle(1'b1, 1'b0, 1'b0, rq);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; hold = 1'b0; restart = 1'b0; req = 2'b00;
        grn = 4'd3; yel = 4'd1; red = 4'd1; wlk = 4'd2;
        model_reset();
        #1;
        compare_all();
        chk("rst_lamp1", int'(light1), 4);
        chk("rst_lamp2", int'(light2), 4);
        @(negedge clk);
        rst_n = 1'b1;

        // basic cycle
        drive_cycle(1'b0, 1'b0, 1'b0, 2'b00);
        chk("idle_exit_phase", int'(phase), 1);
        chk("idle_exit_cnt", int'(cnt), 3);
        for (int i = 0; i < 10; i++) begin
            do_tick(2'b00);
            chk("basic_phase", int'(phase), exp_ph[i]);
            chk("basic_cnt", int'(cnt), exp_ct[i]);
        end

        // pedestrian insertion
        drive_cycle(1'b0, 1'b0, 1'b0, 2'b01);
        chk("ped_latch", int'(pend), 1);
        repeat (5) do_tick(2'b00);
        chk("walk_entry_phase", int'(phase), 7);
        chk("walk_entry_lamps", int'(walk), 1);
        chk("walk_entry_pend", int'(pend), 0);
        do_tick(2'b00);
        chk("walk_hold_lamps", int'(walk), 1);
        do_tick(2'b00);
        chk("walk_exit_phase", int'(phase), 4);
        chk("walk_exit_lamps", int'(walk), 0);
        repeat (5) do_tick(2'b00);
        chk("no_walk_after_arb", int'(phase), 1);

        // request coinciding with AR_A exit, then request during WALK
        repeat (4) do_tick(2'b00);
        chk("at_ar_a", int'(phase), 3);
        do_tick(2'b01);
        chk("coincident_walk", int'(phase), 7);
        chk("coincident_lamps", int'(walk), 1);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'b10);
        chk("req_in_walk_pend", int'(pend), 2);
        chk("req_in_walk_lamps", int'(walk), 1);
        repeat (2) do_tick(2'b00);
        chk("back_to_g2", int'(phase), 4);
        chk("still_pending", int'(pend), 2);
        repeat (5) do_tick(2'b00);
        chk("second_walk", int'(phase), 7);
        chk("second_walk_lamps", int'(walk), 2);
        repeat (2) do_tick(2'b00);
        chk("return_g1", int'(phase), 1);

        // hold and zero length
        repeat (6) do_tick(2'b00);
        chk("pre_hold_phase", int'(phase), 4);
        chk("pre_hold_cnt", int'(cnt), 2);
        yel = 4'd0;
        repeat (10) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 2'b00);
            repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 2'b00);
        end
        chk("hold_phase", int'(phase), 4);
        chk("hold_cnt", int'(cnt), 2);
        do_tick(2'b00);
        chk("post_hold_cnt", int'(cnt), 1);
        do_tick(2'b00);
        chk("y2_zero_len_phase", int'(phase), 5);
        chk("y2_zero_len_cnt", int'(cnt), 1);
        do_tick(2'b00);
        chk("y2_one_tick", int'(phase), 6);
        yel = 4'd1;
        do_tick(2'b00);

        // restart with tick and hold, then async reset mid-WALK
        drive_cycle(1'b0, 1'b0, 1'b0, 2'b11);
        drive_cycle(1'b1, 1'b1, 1'b1, 2'b00);
        chk("restart_phase", int'(phase), 0);
        chk("restart_pend", int'(pend), 3);
        chk("restart_done", int'(done), 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 2'b00);
        chk("restart_to_g1", int'(phase), 1);
        repeat (5) do_tick(2'b00);
        chk("walk_before_reset", int'(phase), 7);
        chk("walk_lamps_before_reset", int'(walk), 3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_lamp1", int'(light1), 4);
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                grn = 4'($urandom_range(0, 5));
                yel = 4'($urandom_range(0, 3));
                red = 4'($urandom_range(0, 3));
                wlk = 4'($urandom_range(0, 4));
            end
            drive_cycle($urandom_range(0, 2) == 0,
                        $urandom_range(0, 9) == 0,
                        $urandom_range(0, 59) == 0,
                        {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Sequences the two-road intersection through its green/yellow/all-red phases and inserts pedestrian WALK phases. Runs on the system clock. Timing comes from a one-cycle-per-second tick from the divider, and pedestrian requests come from debounced button pulses. Phase lengths come from the configuration registers. A hold input freezes the sequence while configuration mode is active.

Parameters:
CNT_W, 4, width of phase length inputs and remaining-count output

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; asynchronous, active-low
tick_i  in  1  one-cycle pulse per second (timing base)
hold_i  in  1  level; freeze phase and counter while high
restart_i  in  1  one-cycle pulse; return to IDLE synchronously
grn_len_i  in  CNT_W  green phase length in ticks
yel_len_i  in  CNT_W  yellow phase length in ticks
red_len_i  in  CNT_W  all-red phase length in ticks
walk_len_i  in  CNT_W  walk phase length in ticks
ped_req_i  in  2  debounced request pulses; bit0 = crossing over road 1, bit1 = crossing over road 2
light1_o  out  3  road 1 lamp, one-hot {red,yellow,green}
light2_o  out  3  road 2 lamp, one-hot {red,yellow,green}
walk_o  out  2  walk lamps, served crossings
ped_pend_o  out  2  latched, unserved requests
cnt_o  out  CNT_W  remaining ticks in current phase
phase_o  out  3  current phase code
phase_done_o  out  1  one-cycle pulse on every phase transition, excluding IDLE exit

Behaviour:
- Phase codes:
  - IDLE=0, G1=1 (road1 green, road2 red), Y1=2, AR_A=3 (all red), G2=4, Y2=5, AR_B=6, WALK=7 (all red).
- Reset (async, rst_ni low):
  - phase_o=IDLE, cnt_o=0, walk_o=0, ped_pend_o=0, phase_done_o=0.
  - light1_o=light2_o=3'b100.
  - Internal return register is set to G1.
- IDLE:
  - Exits to G1 on the next clock, independent of tick_i.
  - hold_i high keeps IDLE.
- Phase entry:
  - cnt_o loads that phase's length input, sampled in the entry cycle only.
  - A length of 0 is treated as 1.
  - Length changes mid-phase do not affect the running count.
- Counting:
  - On tick_i with hold_i low, if cnt_o>1, cnt_o decrements.
  - On tick_i with hold_i low, if cnt_o==1, the phase transitions in that same cycle and the next phase's length loads.
  - Each phase therefore lasts exactly its length in ticks.
- Transition order:
  - G1→Y1→AR_A; G2→Y2→AR_B.
  - AR_A exit:
    - If ped_pend_o or ped_req_i is nonzero, go to WALK with return=G2.
    - Otherwise go to G2.
  - AR_B exit:
    - If ped_pend_o or ped_req_i is nonzero, go to WALK with return=G1.
    - Otherwise go to G1.
  - WALK exit goes to the return phase.
  - At most one WALK per all-red phase.
- Request latching:
  - ped_pend_o[i] sets on ped_req_i[i] in any phase, including during hold.
- WALK entry:
  - walk_o is loaded with (ped_pend_o | ped_req_i) for that cycle.
  - The served bits clear from ped_pend_o.
  - walk_o is constant throughout WALK and goes to 0 on exit.
  - Requests arriving during WALK stay pending for the next all-red phase.
- Lamp outputs:
  - G1: light1=001, light2=100.
  - Y1: light1=010, light2=100.
  - G2/Y2: mirror of G1/Y1.
  - AR_A, AR_B, WALK, IDLE: both 100.
- hold_i high:
  - phase_o and cnt_o are frozen, ticks are ignored (not deferred), and outputs are held.
- restart_i:
  - Next state is IDLE, cnt_o=0, walk_o=0, return=G1.
  - ped_pend_o is preserved.
  - restart_i has priority over hold_i and tick_i.
- phase_done_o:
  - Registered.
  - High in the cycle after any transition out of G1, Y1, AR_A, G2, Y2, AR_B or WALK.
  - Not asserted for restart.
- Priority in one cycle: rst_ni > restart_i > hold_i > tick_i.

Test Plan:
1. Basic cycle
   - Stimulus: reset, then grn=3, yel=1, red=1, no requests, tick every 4 clocks.
   - Required response: phases 1,2,3,4,5,6,1, with durations 3,1,1,3,1,1 ticks; cnt_o sequence in G1 is 3,2,1; lamp codes per phase as specified.
2. Pedestrian insertion
   - Stimulus: ped_req_i=01 pulse during G1, walk_len=2.
   - Required response:
     - After AR_A: WALK, walk_o=01 for 2 ticks, then G2.
     - ped_pend_o returns to 0 at WALK entry.
     - No WALK after AR_B.
3. Request during WALK and simultaneous request
   - Stimulus: ped_req_i=10 pulse during WALK.
   - Required response: stays pending, served after AR_B with walk_o=10, return G1.
   - Stimulus: ped_req_i pulse coinciding with the AR_A exit tick.
   - Required response: WALK is entered in that same transition.
4. Hold and zero length
   - Stimulus: hold_i high for 10 ticks in G2 with cnt_o=2.
   - Required response: phase and cnt_o are frozen; after release, 2 further ticks to Y2.
   - Stimulus: yel_len=0.
   - Required response: yellow lasts 1 tick.
5. Restart and async reset
   - Stimulus: restart_i together with tick_i and hold_i high.
   - Required response: IDLE next cycle, pending preserved, G1 on the following clock.
   - Stimulus: rst_ni low mid-WALK.
   - Required response: immediate IDLE, walk_o=0, pending cleared, both lamps 100.
